half_adder_cell: RTL and testbench

Bit-sliced registered half adder: each of WIDTH lanes adds two 1-bit operands and produces a sum bit (XOR) and a carry bit (AND). It is the leaf arithmetic primitive of the 64-bit single-cycle CPU datapath, used to build full adders and incrementers. Results are captured in an output register one clock after a valid input, with a valid flag travelling alongside.

---
 rtl/half_adder_pkg.sv | 19 +
 rtl/half_adder_cell_if.sv | 40 ++++
 rtl/half_adder_lane.sv | 12 +
 rtl/half_adder_cell.sv | 71 +++++++
 tb/tb_half_adder_cell.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/half_adder_pkg.sv
// Shared constants and the per-lane result type for the registered half-adder cell.
package half_adder_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;

  typedef struct packed {
    logic sum;
    logic carry;
  } lane_result_t;

  function automatic lane_result_t half_add(input logic a, input logic b);
    lane_result_t res;
    res.sum   = a ^ b;
    res.carry = a & b;
    return res;
  endfunction

endpackage

// File: rtl/half_adder_cell_if.sv
// Operand/result bundle for half_adder_cell. The carry_cnt signal exists only
// when HALF_ADDER_CARRY_CNT_EN is defined.
interface half_adder_cell_if #(
  parameter int WIDTH = half_adder_pkg::DEFAULT_WIDTH,
  parameter int CNT_W = half_adder_pkg::DEFAULT_CNT_W
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic             carry_any;

`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output in_valid, a, b,
    input  out_valid, sum, carry, carry_any, carry_cnt
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, sum, carry, carry_any, carry_cnt
  );
`else
  modport master (
    output in_valid, a, b,
    input  out_valid, sum, carry, carry_any
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, sum, carry, carry_any
  );
`endif

endinterface

// File: rtl/half_adder_lane.sv
// One purely combinational half-adder lane: sum = a ^ b, carry = a & b.
module half_adder_lane
  import half_adder_pkg::*;
(
  input  logic         a,
  input  logic         b,
  output lane_result_t res
);

  assign res = half_add(a, b);

endmodule

// File: rtl/half_adder_cell.sv
// WIDTH independent registered half-adder lanes with a travelling valid flag.
// Define HALF_ADDER_CARRY_CNT_EN to add the saturating carry-event counter.
module half_adder_cell
  import half_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  half_adder_cell_if.slave  bus
);

  lane_result_t     lane_res [WIDTH];
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] carry_next;

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic             out_valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_lane u_lane (
      .a   (bus.a[i]),
      .b   (bus.b[i]),
      .res (lane_res[i])
    );
    assign sum_next[i]   = lane_res[i].sum;
    assign carry_next[i] = lane_res[i].carry;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; result registers load only on in_valid, so a/b are
  // ignored (even if X) while the result is being held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q   <= sum_next;
        carry_q <= carry_next;
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = out_valid_q;
  assign bus.carry_any = |carry_q;

`ifdef HALF_ADDER_CARRY_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] carry_cnt_q;

  // Counts accepted inputs with any carrying lane; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt_q <= '0;
    end else if (bus.in_valid && (|carry_next) && (carry_cnt_q != CNT_MAX)) begin
      carry_cnt_q <= carry_cnt_q + 1'b1;
    end
  end

  assign bus.carry_cnt = carry_cnt_q;
`endif

endmodule

// File: tb/tb_half_adder_cell.sv
// Directed bench for half_adder_cell at WIDTH 1, 8 and 64 with a per-cycle
// arithmetic reference model and hand-computed spot checks.
module tb_half_adder_cell;

  logic clk;
  logic rst_n;

  int tests_run = 0;
  int tests_failed = 0;

  half_adder_cell_if #(.WIDTH(1),  .CNT_W(2))  bus1  ();
  half_adder_cell_if #(.WIDTH(8),  .CNT_W(16)) bus8  ();
  half_adder_cell_if #(.WIDTH(64), .CNT_W(16)) bus64 ();

  half_adder_cell #(.WIDTH(1),  .CNT_W(2))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  half_adder_cell #(.WIDTH(8),  .CNT_W(16)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  half_adder_cell #(.WIDTH(64), .CNT_W(16)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each lane adds its two bits as integers; the low bit of the
  // total is the sum, the high bit the carry.
  function automatic logic [63:0] ref_sum(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] r = '0;
    for (int i = 0; i < w; i++) begin
      int t = int'(a[i]) + int'(b[i]);
      r[i] = (t % 2) == 1;
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_carry(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] r = '0;
    for (int i = 0; i < w; i++) begin
      int t = int'(a[i]) + int'(b[i]);
      r[i] = (t / 2) == 1;
    end
    return r;
  endfunction

  logic [63:0] m_sum   [3];
  logic [63:0] m_carry [3];
  logic        m_ov    [3];
  int          m_cnt1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_sum[k]   <= '0;
        m_carry[k] <= '0;
        m_ov[k]    <= 1'b0;
      end
      m_cnt1 <= 0;
    end else begin
      m_ov[0] <= bus1.in_valid;
      m_ov[1] <= bus8.in_valid;
      m_ov[2] <= bus64.in_valid;
      if (bus1.in_valid) begin
        m_sum[0]   <= ref_sum(64'(bus1.a), 64'(bus1.b), 1);
        m_carry[0] <= ref_carry(64'(bus1.a), 64'(bus1.b), 1);
        if (ref_carry(64'(bus1.a), 64'(bus1.b), 1) != 0 && m_cnt1 < 3)
          m_cnt1 <= m_cnt1 + 1;
      end
      if (bus8.in_valid) begin
        m_sum[1]   <= ref_sum(64'(bus8.a), 64'(bus8.b), 8);
        m_carry[1] <= ref_carry(64'(bus8.a), 64'(bus8.b), 8);
      end
      if (bus64.in_valid) begin
        m_sum[2]   <= ref_sum(bus64.a, bus64.b, 64);
        m_carry[2] <= ref_carry(bus64.a, bus64.b, 64);
      end
    end
  end

  task automatic cmp_lane_set(input string tag, input int k, input logic [63:0] sum,
                              input logic [63:0] carry, input logic ov, input logic any);
    check({tag, ".out_valid"}, 64'(ov), 64'(m_ov[k]));
    check({tag, ".sum"}, sum, m_sum[k]);
    check({tag, ".carry"}, carry, m_carry[k]);
    if (m_ov[k]) check({tag, ".carry_any"}, 64'(any), 64'(m_carry[k] != 0));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      cmp_lane_set("m1",  0, 64'(bus1.sum), 64'(bus1.carry), bus1.out_valid, bus1.carry_any);
      cmp_lane_set("m8",  1, 64'(bus8.sum), 64'(bus8.carry), bus8.out_valid, bus8.carry_any);
      cmp_lane_set("m64", 2, bus64.sum, bus64.carry, bus64.out_valid, bus64.carry_any);
`ifdef HALF_ADDER_CARRY_CNT_EN
      check("m1.carry_cnt", 64'(bus1.carry_cnt), 64'(m_cnt1));
`endif
    end
  end

  localparam logic [7:0] TAB_A8 [6] = '{8'hFF, 8'h00, 8'hAA, 8'h0F, 8'h81, 8'h3C};
  localparam logic [7:0] TAB_B8 [6] = '{8'hFF, 8'h00, 8'h55, 8'h01, 8'h81, 8'hF0};

  task automatic drive1(input logic v, input logic a, input logic b);
    bus1.in_valid = v;
    bus1.a = a;
    bus1.b = b;
  endtask

  initial begin
    rst_n = 1'b1;
    drive1(1'b0, 1'b0, 1'b0);
    bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;
    bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0;

    #1 rst_n = 1'b0;
    #2;
    check("rst.sum1",   64'(bus1.sum), 64'h0);
    check("rst.carry1", 64'(bus1.carry), 64'h0);
    check("rst.ov1",    64'(bus1.out_valid), 64'h0);
    check("rst.any64",  64'(bus64.carry_any), 64'h0);
`ifdef HALF_ADDER_CARRY_CNT_EN
    check("rst.cnt1",   64'(bus1.carry_cnt), 64'h0);
`endif

    @(negedge clk);
    rst_n = 1'b1;
    drive1(1'b1, 1'b0, 1'b0);
    bus8.in_valid = 1'b1;  bus8.a = 8'hF0; bus8.b = 8'hCC;
    bus64.in_valid = 1'b1; bus64.a = '1;   bus64.b = 64'h1;

    @(negedge clk);
    check("v00.sum",   64'(bus1.sum), 64'h0);
    check("v00.carry", 64'(bus1.carry), 64'h0);
    check("v00.ov",    64'(bus1.out_valid), 64'h1);
    check("w8.sum",    64'(bus8.sum), 64'h3C);
    check("w8.carry",  64'(bus8.carry), 64'hC0);
    check("w8.any",    64'(bus8.carry_any), 64'h1);
    check("w64.sum",   bus64.sum, 64'hFFFF_FFFF_FFFF_FFFE);
    check("w64.carry", bus64.carry, 64'h1);
    drive1(1'b1, 1'b0, 1'b1);
    bus8.in_valid = 1'b0;  bus8.a = 'x; bus8.b = 'x;
    bus64.in_valid = 1'b0;

    @(negedge clk);
    check("v01.sum",   64'(bus1.sum), 64'h1);
    check("v01.carry", 64'(bus1.carry), 64'h0);
    check("w8hold.sum",   64'(bus8.sum), 64'h3C);
    check("w8hold.carry", 64'(bus8.carry), 64'hC0);
    check("w8hold.ov",    64'(bus8.out_valid), 64'h0);
    drive1(1'b1, 1'b1, 1'b0);
    bus8.a = '0; bus8.b = '0;

    @(negedge clk);
    check("v10.sum",   64'(bus1.sum), 64'h1);
    check("v10.carry", 64'(bus1.carry), 64'h0);
    drive1(1'b1, 1'b1, 1'b1);

    @(negedge clk);
    check("v11.sum",   64'(bus1.sum), 64'h0);
    check("v11.carry", 64'(bus1.carry), 64'h1);
    check("v11.ov",    64'(bus1.out_valid), 64'h1);
`ifdef HALF_ADDER_CARRY_CNT_EN
    check("v11.cnt",   64'(bus1.carry_cnt), 64'h1);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("midrst.sum",   64'(bus1.sum), 64'h0);
    check("midrst.carry", 64'(bus1.carry), 64'h0);
    check("midrst.ov",    64'(bus1.out_valid), 64'h0);
    check("midrst.w8sum", 64'(bus8.sum), 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.ov",    64'(bus1.out_valid), 64'h1);
    check("post_rst.carry", 64'(bus1.carry), 64'h1);
    drive1(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    check("hold.sum",   64'(bus1.sum), 64'h0);
    check("hold.carry", 64'(bus1.carry), 64'h1);
    check("hold.ov",    64'(bus1.out_valid), 64'h0);

    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive1(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
`ifdef HALF_ADDER_CARRY_CNT_EN
      check($sformatf("sat.cnt%0d", i), 64'(bus1.carry_cnt), 64'((i < 3) ? i + 1 : 3));
`endif
    end
    drive1(1'b0, 1'b0, 1'b0);
    @(negedge clk);
`ifdef HALF_ADDER_CARRY_CNT_EN
    check("sat.idle", 64'(bus1.carry_cnt), 64'h3);
`endif

    for (int i = 0; i < 6; i++) begin
      bus8.in_valid = (i != 4);
      bus8.a = TAB_A8[i];
      bus8.b = TAB_B8[i];
      bus64.in_valid = 1'b1;
      bus64.a = {8{TAB_A8[i]}};
      bus64.b = {TAB_B8[i], 56'h0};
      drive1(1'(i % 2), 1'(i % 3 == 0), 1'(i < 3));
      @(negedge clk);
    end
    check("tab.w8sum",   64'(bus8.sum), 64'hCC);
    check("tab.w8carry", 64'(bus8.carry), 64'h30);
    bus8.in_valid = 1'b0;
    bus64.in_valid = 1'b0;
    drive1(1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
